// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: reflected CRC-32 byte step, CRC constants,
// receive status bit positions and the FCS-checker state encoding.
package eth_pkg;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    localparam int LEN_W    = 11;
    localparam int ERR_W    = 3;
    localparam int ERR_CRC  = 0;
    localparam int ERR_RUNT = 1;
    localparam int ERR_OVER = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_FLUSH = 2'd2
    } rx_state_e;

    // LSB-first CRC update over one byte; register is never complemented here.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_rx_fcs_check_if.sv
// Receive byte stream in, FCS-stripped byte stream and end-of-frame status out.
interface eth_rx_fcs_check_if;
    import eth_pkg::*;

    logic             Rx_Frame_Vld;
    logic             Rx_Byte_Rdy;
    logic [7:0]       Rx_Byte;
    logic [7:0]       Data_Byte;
    logic             Data_Byte_Rdy;
    logic             Data_Sof;
    logic             Frame_Done;
    logic             Frame_Good;
    logic [ERR_W-1:0] Frame_Err;
    logic [LEN_W-1:0] Frame_Len;

    modport master (
        output Rx_Frame_Vld, Rx_Byte_Rdy, Rx_Byte,
        input  Data_Byte, Data_Byte_Rdy, Data_Sof,
        input  Frame_Done, Frame_Good, Frame_Err, Frame_Len
    );

    modport slave (
        input  Rx_Frame_Vld, Rx_Byte_Rdy, Rx_Byte,
        output Data_Byte, Data_Byte_Rdy, Data_Sof,
        output Frame_Done, Frame_Good, Frame_Err, Frame_Len
    );

endinterface

// File: rtl/eth_rx_fcs_dly.sv
// Four-byte delay line that holds back the trailing FCS; once full, every push
// emits the oldest byte, the first emission after a flush flagged as start of frame.
module eth_rx_fcs_dly (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  logic       flush_i,
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o,
    output logic       emit_o,
    output logic       sof_o
);

    logic [3:0][7:0] sh_q, sh_d;
    logic [2:0]      fill_q, fill_d;
    logic            pend_q, pend_d;
    logic [7:0]      byte_q, byte_d;
    logic            emit_q, emit_d;
    logic            sof_q, sof_d;

    always_comb begin
        sh_d   = sh_q;
        fill_d = fill_q;
        pend_d = pend_q;
        byte_d = byte_q;
        emit_d = 1'b0;
        sof_d  = 1'b0;
        if (flush_i) begin
            fill_d = 3'd0;
            pend_d = 1'b1;
        end else if (push_i) begin
            // Entry 3 is the oldest byte; it leaves only when all four are occupied.
            sh_d = {sh_q[2:0], byte_i};
            if (fill_q == 3'd4) begin
                emit_d = 1'b1;
                byte_d = sh_q[3];
                sof_d  = pend_q;
                pend_d = 1'b0;
            end else begin
                fill_d = fill_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_q   <= '0;
            fill_q <= 3'd0;
            pend_q <= 1'b1;
            byte_q <= 8'h00;
            emit_q <= 1'b0;
            sof_q  <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            fill_q <= fill_d;
            pend_q <= pend_d;
            byte_q <= byte_d;
            emit_q <= emit_d;
            sof_q  <= sof_d;
        end
    end

    assign byte_o = byte_q;
    assign emit_o = emit_q;
    assign sof_o  = sof_q;

endmodule

// File: rtl/eth_rx_fcs_check.sv
// Receive FCS checker: CRC-32 over DA..FCS, FCS stripped through a delay line,
// length/runt/oversize/CRC status strobed once per frame.
module eth_rx_fcs_check
    import eth_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input logic              Clk,
    input logic              Rst_n,
    eth_rx_fcs_check_if.slave bus
);

    localparam logic [LEN_W-1:0] MIN_L   = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_SAT = '1;

    rx_state_e        state_q;
    logic             first_q;
    logic [31:0]      lfsr_q, lfsr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             done_q, good_q;
    logic [ERR_W-1:0] err_q, err_d;
    logic [LEN_W-1:0] flen_q;
    logic             accept;
    logic             frame_end;

    // A frame already in flight when reset releases is not ours to check.
    assign accept = bus.Rx_Frame_Vld & bus.Rx_Byte_Rdy &
                    ((state_q == ST_RECV) | ((state_q == ST_IDLE) & ~first_q));
    assign frame_end = (state_q == ST_RECV) & ~bus.Rx_Frame_Vld;

    always_comb begin
        lfsr_d = lfsr_q;
        len_d  = len_q;
        if (frame_end) begin
            lfsr_d = CRC_INIT;
            len_d  = '0;
        end else if (accept) begin
            lfsr_d = crc32_byte(lfsr_q, bus.Rx_Byte);
            if (len_q != LEN_SAT) len_d = len_q + 1'b1;
        end
    end

    always_comb begin
        err_d           = '0;
        err_d[ERR_CRC]  = (lfsr_q != CRC_RESIDUE);
        err_d[ERR_RUNT] = (len_q < MIN_L);
        err_d[ERR_OVER] = (len_q > MAX_L);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            first_q <= 1'b1;
            lfsr_q  <= CRC_INIT;
            len_q   <= '0;
            done_q  <= 1'b0;
            good_q  <= 1'b0;
            err_q   <= '0;
            flen_q  <= '0;
        end else begin
            first_q <= 1'b0;
            done_q  <= 1'b0;
            lfsr_q  <= lfsr_d;
            len_q   <= len_d;
            case (state_q)
                ST_IDLE: begin
                    if (bus.Rx_Frame_Vld) state_q <= first_q ? ST_FLUSH : ST_RECV;
                end
                ST_RECV: begin
                    if (!bus.Rx_Frame_Vld) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                        good_q  <= (err_d == '0);
                        err_q   <= err_d;
                        flen_q  <= len_q;
                    end
                end
                ST_FLUSH: begin
                    if (!bus.Rx_Frame_Vld) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    eth_rx_fcs_dly u_dly (
        .clk_i   (Clk),
        .rst_ni  (Rst_n),
        .push_i  (accept),
        .flush_i (frame_end),
        .byte_i  (bus.Rx_Byte),
        .byte_o  (bus.Data_Byte),
        .emit_o  (bus.Data_Byte_Rdy),
        .sof_o   (bus.Data_Sof)
    );

    assign bus.Frame_Done = done_q;
    assign bus.Frame_Good = good_q;
    assign bus.Frame_Err  = err_q;
    assign bus.Frame_Len  = flen_q;

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Directed bench for eth_rx_fcs_check: known-FCS vector, good/bad/oversize frames,
// back-to-back frames and reset in mid-frame.
module tb_eth_rx_fcs_check;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    eth_rx_fcs_check_if bus();

    eth_rx_fcs_check dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    bit         sof_q[$];

    int          cyc = 0;
    int          done_cnt, good_cnt, sof_cyc, done_cyc, acc4_cyc, low_cyc;
    logic [10:0] st_len;
    logic [2:0]  st_err;
    logic        st_good;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.Data_Byte_Rdy) begin
            rx_q.push_back(bus.Data_Byte);
            sof_q.push_back(bus.Data_Sof);
            if (bus.Data_Sof && sof_cyc < 0) sof_cyc = cyc;
        end
        if (bus.Frame_Done) begin
            done_cnt++;
            if (bus.Frame_Good) good_cnt++;
            st_len   = bus.Frame_Len;
            st_err   = bus.Frame_Err;
            st_good  = bus.Frame_Good;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_obs();
        rx_q.delete();
        sof_q.delete();
        done_cnt = 0;
        good_cnt = 0;
        sof_cyc  = -1;
        done_cyc = -1;
    endtask

    task automatic build_seq(input int n);
        tx_q.delete();
        for (int i = 0; i < n; i++) tx_q.push_back(8'(i));
    endtask

    // Bit-serial reference CRC over tx_q, FCS appended least significant byte first.
    task automatic add_fcs();
        logic [31:0] c;
        logic        fb;
        c = 32'hFFFFFFFF;
        foreach (tx_q[k]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ tx_q[k][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        c = ~c;
        for (int i = 0; i < 4; i++) tx_q.push_back(c[8*i +: 8]);
    endtask

    task automatic drive_byte(input logic [7:0] b);
        bus.Rx_Byte_Rdy = 1'b1;
        bus.Rx_Byte     = b;
        @(posedge clk); #1;
    endtask

    task automatic send(input bit gaps);
        int g;
        bus.Rx_Frame_Vld = 1'b1;
        foreach (tx_q[k]) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                repeat (g) begin
                    bus.Rx_Byte_Rdy = 1'b0;
                    @(posedge clk); #1;
                end
            end
            if (k == 4) acc4_cyc = cyc;
            drive_byte(tx_q[k]);
        end
        bus.Rx_Frame_Vld = 1'b0;
        bus.Rx_Byte_Rdy  = 1'b0;
        low_cyc = cyc;
        @(posedge clk); #1;
    endtask

    task automatic check_frame(input string tag, input int n_fwd, input int len,
                               input logic [2:0] err, input bit full_data);
        int nsof;
        repeat (3) @(posedge clk);
        #1;
        chk({tag, ".done"}, done_cnt, 1);
        chk({tag, ".len"}, st_len, len);
        chk({tag, ".err"}, st_err, err);
        chk({tag, ".good"}, st_good, (err == 3'b000));
        chk({tag, ".nfwd"}, rx_q.size(), n_fwd);
        if (full_data) begin
            for (int i = 0; i < n_fwd && i < rx_q.size(); i++)
                chk($sformatf("%s.data%0d", tag, i), rx_q[i], tx_q[i]);
        end
        nsof = 0;
        foreach (sof_q[i]) if (sof_q[i]) nsof++;
        chk({tag, ".nsof"}, nsof, (n_fwd > 0) ? 1 : 0);
        if (sof_q.size() > 0) chk({tag, ".sof0"}, sof_q[0], 1);
    endtask

    initial begin
        bus.Rx_Frame_Vld = 1'b0;
        bus.Rx_Byte_Rdy  = 1'b0;
        bus.Rx_Byte      = 8'h00;
        clear_obs();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.outs", {bus.Data_Byte, bus.Data_Byte_Rdy, bus.Data_Sof, bus.Frame_Done,
                           bus.Frame_Good, bus.Frame_Err, bus.Frame_Len}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // "123456789" with its known FCS: 13 bytes, so CRC good but runt.
        tx_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                 8'h26, 8'h39, 8'hF4, 8'hCB};
        clear_obs();
        send(1'b0);
        check_frame("chk9", 9, 13, 3'b010, 1'b1);
        chk("chk9.sof_lat", sof_cyc, acc4_cyc + 1);
        chk("chk9.done_lat", done_cyc, low_cyc + 1);

        build_seq(60);
        add_fcs();
        clear_obs();
        send(1'b1);
        check_frame("good64", 60, 64, 3'b000, 1'b1);

        build_seq(60);
        add_fcs();
        tx_q[10] = tx_q[10] ^ 8'h01;
        clear_obs();
        send(1'b1);
        check_frame("crcerr", 60, 64, 3'b001, 1'b1);

        build_seq(1596);
        add_fcs();
        clear_obs();
        send(1'b0);
        check_frame("over1600", 1596, 1600, 3'b100, 1'b0);

        build_seq(2996);
        add_fcs();
        clear_obs();
        send(1'b0);
        check_frame("sat3000", 2996, 2047, 3'b100, 1'b0);

        // Two good frames separated by a single Vld-low cycle.
        build_seq(60);
        add_fcs();
        clear_obs();
        send(1'b0);
        send(1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("b2b.done", done_cnt, 2);
        chk("b2b.good", good_cnt, 2);
        chk("b2b.nfwd", rx_q.size(), 120);
        if (rx_q.size() == 120) begin
            chk("b2b.sof0", sof_q[0], 1);
            chk("b2b.sof60", sof_q[60], 1);
            chk("b2b.byte60", rx_q[60], 8'h00);
            chk("b2b.byte119", rx_q[119], 8'h3B);
        end

        // Reset pulse at byte 20 with Vld held high through and after reset.
        build_seq(60);
        add_fcs();
        clear_obs();
        bus.Rx_Frame_Vld = 1'b1;
        for (int k = 0; k < 20; k++) drive_byte(tx_q[k]);
        rst_n = 1'b0;
        #1;
        chk("midrst.outs", {bus.Data_Byte, bus.Data_Byte_Rdy, bus.Data_Sof, bus.Frame_Done,
                            bus.Frame_Good, bus.Frame_Err, bus.Frame_Len}, 0);
        clear_obs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 20; k < 64; k++) drive_byte(tx_q[k]);
        bus.Rx_Frame_Vld = 1'b0;
        bus.Rx_Byte_Rdy  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("midrst.done", done_cnt, 0);
        chk("midrst.nfwd", rx_q.size(), 0);

        clear_obs();
        send(1'b0);
        check_frame("postrst", 60, 64, 3'b000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no end want end");
        $fatal(1, "timeout");
    end

endmodule
